// File: rtl/mmc_cmd_control_layer_cmd24.sv
// SPI-mode MMC/SD single-block write (CMD24) sequencer: command frame, R1 poll,
// start token, 512 data bytes from the sector buffer, dummy CRC, data response, busy wait.
module mmc_cmd_control_layer_cmd24 #(
  parameter int unsigned P_RESP_RETRY = 16
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_START,
  input  logic [31:0] iCMD_ADDR,
  output logic        oCMD_END,
  output logic        oCMD_ERR,
  output logic        oBUFF_REQ,
  output logic [6:0]  oBUFF_ADDR,
  input  logic        iBUFF_VALID,
  input  logic [31:0] iBUFF_DATA,
  output logic        oMMC_REQ,
  input  logic        iMMC_BUSY,
  output logic        oMMC_CS,
  output logic [7:0]  oMMC_DATA,
  input  logic        iMMC_VALID,
  input  logic [7:0]  iMMC_DATA
);

  localparam int unsigned RW = $clog2(P_RESP_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(P_RESP_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_RESP_REQ, S_RESP_GET, S_GAP, S_TOKEN, S_FETCH, S_FWAIT,
    S_DATA, S_CRC, S_DRESP_REQ, S_DRESP_GET, S_BUSY_REQ, S_BUSY_GET, S_END
  } state_t;

  state_t          state, state_d;
  logic [2:0]      count, count_d;
  logic [1:0]      bsel, bsel_d;
  logic [6:0]      word, word_d;
  logic [RW-1:0]   retry, retry_d;
  logic [31:0]     addr, addr_d;
  logic [31:0]     wdata, wdata_d;
  logic            err, err_d;
  logic            is_send;
  logic            accept;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state <= S_IDLE;
      count <= '0;
      bsel  <= '0;
      word  <= '0;
      retry <= '0;
      addr  <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else if (iRESET_SYNC) begin
      state <= S_IDLE;
      count <= '0;
      bsel  <= '0;
      word  <= '0;
      retry <= '0;
      addr  <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      bsel  <= bsel_d;
      word  <= word_d;
      retry <= retry_d;
      addr  <= addr_d;
      wdata <= wdata_d;
      err   <= err_d;
    end
  end

  always_comb begin
    is_send = state inside {S_CMD, S_RESP_REQ, S_GAP, S_TOKEN, S_DATA,
                            S_CRC, S_DRESP_REQ, S_BUSY_REQ};
    oMMC_REQ   = is_send && !iMMC_BUSY;
    accept     = oMMC_REQ;
    oMMC_CS    = (state == S_IDLE) || (state == S_END);
    oCMD_END   = (state == S_END);
    oCMD_ERR   = err;
    oBUFF_REQ  = (state == S_FETCH);
    oBUFF_ADDR = word;
    oMMC_DATA  = 8'hFF;
    case (state)
      S_CMD: begin
        case (count)
          3'd0:    oMMC_DATA = 8'h58;
          3'd1:    oMMC_DATA = addr[31:24];
          3'd2:    oMMC_DATA = addr[23:16];
          3'd3:    oMMC_DATA = addr[15:8];
          3'd4:    oMMC_DATA = addr[7:0];
          default: oMMC_DATA = 8'h01;
        endcase
      end
      S_TOKEN: oMMC_DATA = 8'hFE;
      S_DATA:  oMMC_DATA = wdata[{bsel, 3'b000} +: 8];
      default: oMMC_DATA = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state;
    count_d = count;
    bsel_d  = bsel;
    word_d  = word;
    retry_d = retry;
    addr_d  = addr;
    wdata_d = wdata;
    err_d   = err;
    case (state)
      S_IDLE: if (iCMD_START) begin
        addr_d  = iCMD_ADDR;
        count_d = '0;
        err_d   = 1'b0;
        state_d = S_CMD;
      end
      // Leave on the sixth acceptance so no request is raised with count==6.
      S_CMD: if (accept) begin
        if (count == 3'd5) begin
          count_d = '0;
          retry_d = '0;
          state_d = S_RESP_REQ;
        end else begin
          count_d = count + 3'd1;
        end
      end
      S_RESP_REQ: if (accept) state_d = S_RESP_GET;
      S_RESP_GET: if (iMMC_VALID) begin
        if (iMMC_DATA == 8'h00) begin
          state_d = S_GAP;
        end else if (iMMC_DATA == 8'hFF && retry < RETRY_MAX) begin
          retry_d = retry + RW'(1);
          state_d = S_RESP_REQ;
        end else begin
          err_d   = 1'b1;
          state_d = S_END;
        end
      end
      S_GAP:   if (accept) state_d = S_TOKEN;
      S_TOKEN: if (accept) begin
        word_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: if (iBUFF_VALID) begin
        wdata_d = iBUFF_DATA;
        bsel_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        bsel_d = bsel + 2'd1;
        if (bsel == 2'd3) begin
          if (word == 7'd127) begin
            count_d = '0;
            state_d = S_CRC;
          end else begin
            word_d  = word + 7'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_CRC: if (accept) begin
        if (count == 3'd1) begin
          count_d = '0;
          state_d = S_DRESP_REQ;
        end else begin
          count_d = count + 3'd1;
        end
      end
      S_DRESP_REQ: if (accept) state_d = S_DRESP_GET;
      S_DRESP_GET: if (iMMC_VALID) begin
        if (iMMC_DATA == 8'hFF) begin
          state_d = S_DRESP_REQ;
        end else if (iMMC_DATA[4:0] == 5'b00101) begin
          state_d = S_BUSY_REQ;
        end else begin
          err_d   = 1'b1;
          state_d = S_END;
        end
      end
      S_BUSY_REQ: if (accept) state_d = S_BUSY_GET;
      S_BUSY_GET: if (iMMC_VALID) begin
        if (iMMC_DATA == 8'h00) state_d = S_BUSY_REQ;
        else                    state_d = S_END;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmc_cmd_control_layer_cmd24.sv
// Directed bench for the CMD24 write sequencer with a byte-level card model and
// a sector-buffer model; transmitted bytes are compared against a built stream.
module tb_mmc_cmd_control_layer_cmd24;

  logic        clk = 1'b0;
  logic        iRESET, iRESET_SYNC, iCMD_START;
  logic [31:0] iCMD_ADDR;
  logic        oCMD_END, oCMD_ERR, oBUFF_REQ;
  logic [6:0]  oBUFF_ADDR;
  logic        iBUFF_VALID;
  logic [31:0] iBUFF_DATA;
  logic        oMMC_REQ, iMMC_BUSY, oMMC_CS;
  logic [7:0]  oMMC_DATA;
  logic        iMMC_VALID;
  logic [7:0]  iMMC_DATA;

  always #5 clk = ~clk;

  mmc_cmd_control_layer_cmd24 #(.P_RESP_RETRY(16)) dut (
    .iCLOCK(clk), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCMD_START(iCMD_START), .iCMD_ADDR(iCMD_ADDR),
    .oCMD_END(oCMD_END), .oCMD_ERR(oCMD_ERR),
    .oBUFF_REQ(oBUFF_REQ), .oBUFF_ADDR(oBUFF_ADDR),
    .iBUFF_VALID(iBUFF_VALID), .iBUFF_DATA(iBUFF_DATA),
    .oMMC_REQ(oMMC_REQ), .iMMC_BUSY(iMMC_BUSY), .oMMC_CS(oMMC_CS),
    .oMMC_DATA(oMMC_DATA), .iMMC_VALID(iMMC_VALID), .iMMC_DATA(iMMC_DATA)
  );

  int checks = 0;
  int errors = 0;

  int         r1_ff, busy_n;
  logic [7:0] r1_v, dresp_v;
  bit         bp, special;

  logic [7:0] tx    [0:1023];
  logic [7:0] exp_b [0:1023];
  int         tx_n, exp_n;
  int         baddr [0:255];
  int         b_n;
  int         end_cnt;
  logic       end_err = 1'b0;

  int         c_pend, c_hold;
  logic [7:0] c_resp;
  int         b_cnt;
  logic [6:0] b_addr;

  function automatic logic [31:0] bword(input logic [6:0] a);
    if (special && a == 7'd0) return 32'h44332211;
    return {4{1'b0, a}};
  endfunction

  function automatic logic [7:0] card_resp(input int idx);
    int base;
    if (idx < 6 + r1_ff) return 8'hFF;
    if (idx == 6 + r1_ff) return r1_v;
    base = 6 + r1_ff + 1;
    if (idx < base + 516) return 8'hFF;
    if (idx == base + 516) return dresp_v;
    if (idx - (base + 517) < busy_n) return 8'h00;
    return 8'hFF;
  endfunction

  // Card / SPI layer: one byte in flight, response valid in the cycle busy drops.
  initial begin
    iMMC_BUSY = 1'b0; iMMC_VALID = 1'b0; iMMC_DATA = 8'hFF; c_pend = 0; c_hold = 0;
    forever begin
      @(negedge clk);
      iMMC_VALID = 1'b0;
      if (c_pend != 0) begin
        if (c_hold > 0) begin
          c_hold--;
          iMMC_BUSY = 1'b1;
        end else begin
          iMMC_BUSY = 1'b0; iMMC_VALID = 1'b1; iMMC_DATA = c_resp; c_pend = 0;
        end
      end else begin
        iMMC_BUSY = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      #1;
      if (oMMC_REQ && !iMMC_BUSY) begin
        if (tx_n < 1024) tx[tx_n] = oMMC_DATA;
        c_resp = card_resp(tx_n);
        tx_n++;
        c_pend = 1;
        c_hold = bp ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  initial begin
    iBUFF_VALID = 1'b0; iBUFF_DATA = '0; b_cnt = 0; b_addr = '0;
    forever begin
      @(negedge clk);
      iBUFF_VALID = 1'b0;
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          iBUFF_VALID = 1'b1;
          iBUFF_DATA  = bword(b_addr);
        end
      end
      if (oBUFF_REQ) begin
        if (b_n < 256) baddr[b_n] = int'(oBUFF_ADDR);
        b_n++;
        b_addr = oBUFF_ADDR;
        b_cnt  = bp ? int'($urandom_range(1, 5)) : 1;
      end
    end
  end

  initial begin
    end_cnt = 0;
    forever begin
      @(negedge clk);
      if (oCMD_END === 1'b1) begin
        end_cnt++;
        end_err = oCMD_ERR;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    exp_b[exp_n] = v;
    exp_n++;
  endtask

  // mode 0: full success, 1: R1 timeout, 2: data response rejected
  task automatic build_exp(input logic [31:0] addr, input int mode);
    logic [31:0] d;
    exp_n = 0;
    push(8'h58); push(addr[31:24]); push(addr[23:16]); push(addr[15:8]); push(addr[7:0]);
    push(8'h01);
    if (mode == 1) begin
      for (int i = 0; i < 17; i++) push(8'hFF);
      return;
    end
    for (int i = 0; i < r1_ff + 1; i++) push(8'hFF);
    push(8'hFF);
    push(8'hFE);
    for (int w = 0; w < 128; w++) begin
      d = bword(7'(w));
      for (int b = 0; b < 4; b++) push(d[8*b +: 8]);
    end
    push(8'hFF); push(8'hFF);
    push(8'hFF);
    if (mode == 0) for (int i = 0; i < busy_n + 1; i++) push(8'hFF);
  endtask

  task automatic start_cmd(input logic [31:0] addr);
    tx_n = 0; b_n = 0; end_cnt = 0;
    @(negedge clk);
    iCMD_ADDR = addr; iCMD_START = 1'b1;
    @(negedge clk);
    iCMD_START = 1'b0;
  endtask

  task automatic scenario(input string tag, input logic [31:0] addr, input int mode,
                          input int exp_err);
    bit done;
    int bad, bbad;
    build_exp(addr, mode);
    start_cmd(addr);
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (end_cnt > 0) done = 1;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_endcnt"}, end_cnt, 1);
    chk({tag, "_err"}, int'(end_err), exp_err);
    chk({tag, "_cs"}, int'(oMMC_CS), 1);
    bad = -1;
    for (int i = 0; i < exp_n && i < tx_n; i++)
      if (bad < 0 && tx[i] !== exp_b[i]) bad = i;
    chk({tag, "_txlen"}, tx_n, exp_n);
    chk({tag, "_txfirstbad"}, bad, -1);
    chk({tag, "_nbuf"}, b_n, (mode == 1) ? 0 : 128);
    bbad = -1;
    for (int i = 0; i < b_n && i < 256; i++)
      if (bbad < 0 && baddr[i] != i) bbad = i;
    chk({tag, "_bufforder"}, bbad, -1);
  endtask

  task automatic reset_mid(input string tag, input bit use_sync);
    bit hit;
    start_cmd(32'h00001200);
    hit = 0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      if (b_n > 40) hit = 1;
    end
    chk({tag, "_reach40"}, int'(hit), 1);
    if (use_sync) iRESET_SYNC = 1'b1;
    else          iRESET = 1'b1;
    repeat (6) @(negedge clk);
    chk({tag, "_cs"}, int'(oMMC_CS), 1);
    chk({tag, "_req"}, int'(oMMC_REQ), 0);
    iRESET = 1'b0; iRESET_SYNC = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_noend"}, end_cnt, 0);
    scenario({tag, "_restart"}, 32'h00001200, 0, 0);
  endtask

  initial begin
    iRESET = 1'b1; iRESET_SYNC = 1'b0; iCMD_START = 1'b0; iCMD_ADDR = '0;
    r1_ff = 2; r1_v = 8'h00; dresp_v = 8'hE5; busy_n = 3; bp = 0; special = 0;
    tx_n = 0; b_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", int'(oMMC_REQ), 0);
    chk("rst_cs", int'(oMMC_CS), 1);
    chk("rst_data", int'(oMMC_DATA), 8'hFF);
    chk("rst_end", int'(oCMD_END), 0);
    chk("rst_err", int'(oCMD_ERR), 0);
    chk("rst_breq", int'(oBUFF_REQ), 0);
    chk("rst_baddr", int'(oBUFF_ADDR), 0);
    iRESET = 1'b0;
    repeat (2) @(negedge clk);

    scenario("nominal", 32'h00001200, 0, 0);

    special = 1;
    scenario("byteorder", 32'hA1B2C3D4, 0, 0);
    chk("byteorder_word0", int'({tx[14], tx[13], tx[12], tx[11]}), 32'h44332211);
    chk("byteorder_token", int'(tx[10]), 8'hFE);
    special = 0;

    r1_ff = 100;
    scenario("r1timeout", 32'h0000BEEF, 1, 1);
    r1_ff = 2;

    dresp_v = 8'h0B;
    scenario("dreject", 32'h00000400, 2, 1);
    dresp_v = 8'hE5;

    r1_v = 8'h04;
    build_exp(32'h00000010, 1);
    start_cmd(32'h00000010);
    for (int i = 0; i < 200 && end_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("r1bad_endcnt", end_cnt, 1);
    chk("r1bad_err", int'(end_err), 1);
    chk("r1bad_txlen", tx_n, 6 + r1_ff + 1);
    chk("r1bad_nbuf", b_n, 0);
    r1_v = 8'h00;

    bp = 1;
    scenario("backpressure", 32'h00001200, 0, 0);
    bp = 0;

    reset_mid("async_mid", 1'b0);
    reset_mid("sync_mid", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
